// File: rtl/alu_pkg.sv
// alu_pkg: opcode values, controller state enum, response kind encoding and opcode classifiers shared by alu_seq_ctrl
package alu_pkg;
  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;
  typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;
  typedef enum logic [1:0] {KIND_NONE, KIND_REG, KIND_MEM, KIND_BRN} kind_t;
  function automatic logic is_muldiv(input logic [4:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
  function automatic kind_t exec_kind(input logic [4:0] op);
    return op <= OP_STW ? KIND_MEM : (op >= OP_BR && op <= OP_JAL) ? KIND_BRN : KIND_REG;
  endfunction
endpackage

// File: rtl/alu_seq_hilo.sv
// alu_seq_hilo: HI/LO register pair; ports clk, clear (sync zero), load, hi_in/lo_in in, hi/lo out
module alu_seq_hilo (
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  always_ff @(posedge clk)
    if (clear) begin
      hi <= '0;
      lo <= '0;
    end else if (load) begin
      hi <= hi_in;
      lo <= lo_in;
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle ALU issue controller; req_* in / alu_* registered out / alu_rc in / rsp_* out / hi_out,lo_out,halted; ALU_SEQ_HILO_EN enables HI/LO
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int SIMPLE_LAT = 1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_ra,
  input  logic [31:0] req_rb,
  input  logic        req_brn_flag,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  output logic [4:0]  alu_opcode,
  output logic        alu_brn_flag,
  input  logic [63:0] alu_rc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_kind,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        halted
);
  localparam logic [3:0] MD_CNT = 4'(MULDIV_LAT - 1);
  localparam logic [3:0] SP_CNT = 4'(SIMPLE_LAT - 1);
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi, lo;
`ifdef ALU_SEQ_HILO_EN
  localparam bit HILO_EN = 1'b1;
  logic hilo_load;
  assign hilo_load = state == EXEC && cnt == '0 && is_muldiv(alu_opcode);
  alu_seq_hilo u_hilo (
    .clk   (clk),
    .clear (clear),
    .load  (hilo_load),
    .hi_in (alu_rc[63:32]),
    .lo_in (alu_rc[31:0]),
    .hi    (hi),
    .lo    (lo)
  );
`else
  localparam bit HILO_EN = 1'b0;
  logic unused_rc_hi;
  assign unused_rc_hi = ^alu_rc[63:32];
  assign hi = '0;
  assign lo = '0;
`endif
  assign req_ready = state == IDLE;
  assign hi_out    = hi;
  assign lo_out    = lo;
  always_ff @(posedge clk)
    if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      alu_ra       <= '0;
      alu_rb       <= '0;
      alu_opcode   <= '0;
      alu_brn_flag <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_kind     <= KIND_NONE;
      halted       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          alu_ra       <= req_ra;
          alu_rb       <= req_rb;
          alu_opcode   <= req_opcode;
          alu_brn_flag <= req_brn_flag;
          rsp_data     <= '0;
          rsp_kind     <= KIND_NONE;
          if (req_opcode == OP_HALT) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (req_opcode == OP_MFHI || req_opcode == OP_MFLO) begin
            state    <= RESP;
            rsp_data <= req_opcode == OP_MFHI ? hi : lo;
            rsp_kind <= HILO_EN ? KIND_REG : KIND_NONE;
          end else if (req_opcode >= OP_IN) begin
            state <= RESP;
          end else begin
            state <= EXEC;
            cnt   <= is_muldiv(req_opcode) ? MD_CNT : SP_CNT;
          end
        end
        EXEC: if (cnt == '0) begin
          state    <= RESP;
          rsp_data <= alu_rc[31:0];
          rsp_kind <= is_muldiv(alu_opcode) ? (HILO_EN ? KIND_NONE : KIND_REG) : exec_kind(alu_opcode);
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (rsp_valid && rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end else begin
          rsp_valid <= 1'b1;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
endmodule
